sccb_init_seq: RTL and testbench

SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

---
 rtl/sccb_init_seq_pkg.sv | 57 +++++
 rtl/sccb_init_rom.sv | 59 +++++
 rtl/sccb_init_seq.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sccb_init_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_init_seq_pkg.sv
// sccb_init_seq_pkg
//   Shared definitions for the SCCB init sequencer, its table ROM and the
//   bench: table entry layout, op encodings, FSM state encodings, bus
//   command/response codes and error codes.
package sccb_init_seq_pkg;

  localparam int OP_W    = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = OP_W + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_CHECK = 2'b10,
    OP_END   = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DELAY     = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_e;

  localparam logic [2:0] MCMD_IDLE  = 3'b000;
  localparam logic [2:0] MCMD_WRITE = 3'b001;
  localparam logic [2:0] MCMD_READ  = 3'b010;

  localparam logic [1:0] SRESP_DVA  = 2'b01;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHECK   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  // Build one table entry from its fields.
  function automatic entry_t mk_entry(input op_e op, input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data);
    entry_t e;
    e.op   = op;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// sccb_init_rom
//   Register-init table for one sensor, read with one cycle of latency.
//   Swap this module (or its table selection) to retarget the sequencer.
// Ports:
//   clk    in   table clock
//   addr   in   P_ROM_AW entry index
//   entry  out  ENTRY_W registered entry {op, addr, data}
// Tables:
//   P_ROM_TABLE 0 : bring-up table (two writes, an ID check, delays, END)
//   P_ROM_TABLE 1 : every slot a WRITE of {addr=index, data=~index}, no END
module sccb_init_rom
  import sccb_init_seq_pkg::*;
#(
  parameter int P_ROM_AW    = 6,
  parameter int P_ROM_TABLE = 0
) (
  input  logic                clk,
  input  logic [P_ROM_AW-1:0] addr,
  output logic [ENTRY_W-1:0]  entry
);

  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] entry_q;

  // Table contents; unlisted slots read as END so a short table stops cleanly.
  function automatic entry_t lookup(input logic [P_ROM_AW-1:0] a);
    entry_t      e;
    logic [31:0] a32;
    a32 = 32'(a);
    e   = mk_entry(OP_END, 8'h00, 8'h00);
    if (P_ROM_TABLE == 1) begin
      e = mk_entry(OP_WRITE, a32[7:0], ~a32[7:0]);
    end else begin
      case (a32)
        32'd0:   e = mk_entry(OP_WRITE, 8'h12, 8'h80);  // soft reset
        32'd1:   e = mk_entry(OP_WRITE, 8'h11, 8'h01);  // clock prescaler
        32'd2:   e = mk_entry(OP_CHECK, 8'h0A, 8'h76);  // product ID
        32'd3:   e = mk_entry(OP_DELAY, 8'h00, 8'h00);
        32'd4:   e = mk_entry(OP_DELAY, 8'h00, 8'h03);  // settle after reset
        32'd5:   e = mk_entry(OP_END,   8'h00, 8'h00);
        default: e = mk_entry(OP_END,   8'h00, 8'h00);
      endcase
    end
    return e;
  endfunction

  // Table lookup for the presented index.
  always_comb begin
    entry_d = lookup(addr);
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/sccb_init_seq.sv
// sccb_init_seq
//   Walks the init table in sccb_init_rom and turns each entry into SCCB
//   bridge commands (WRITE / CHECK-read), millisecond delays or completion.
// Ports:
//   sccb_clk      in   clock for all logic
//   sccb_reset_n  in   asynchronous active-low reset
//   start         in   one-cycle pulse, (re)run table from entry 0
//   mcmd          out  3   bridge command: 000 idle, 001 write, 010 read
//   maddr         out  15  {P_DEV_ID, register address}
//   mdata         out  8   write data
//   scmdaccept    in   bridge idle / accepting
//   sresp         in   2   bridge response, 01 = DVA
//   sdata         in   8   read data, valid with DVA on a read
//   busy          out  sequence running
//   done          out  sticky, END entry reached
//   error         out  sticky, sequence aborted
//   err_code      out  2   01 timeout, 10 check mismatch, 11 table overrun
//   err_idx       out  P_ROM_AW entry index at abort
module sccb_init_seq
  import sccb_init_seq_pkg::*;
#(
  parameter logic [6:0]  P_DEV_ID     = 7'h21,
  parameter int          P_ROM_AW     = 6,
  parameter logic [15:0] P_MS_DIV     = 16'd50000,
  parameter logic [23:0] P_TIMEOUT    = 24'd2000000,
  parameter bit          P_AUTO_START = 1'b1,
  parameter int          P_ROM_TABLE  = 0   // table selection inside sccb_init_rom
) (
  input  logic                sccb_clk,
  input  logic                sccb_reset_n,
  input  logic                start,
  output logic [2:0]          mcmd,
  output logic [14:0]         maddr,
  output logic [7:0]          mdata,
  input  logic                scmdaccept,
  input  logic [1:0]          sresp,
  input  logic [7:0]          sdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [P_ROM_AW-1:0] err_idx
);

  localparam logic [P_ROM_AW-1:0] IDX_LAST = '1;
  localparam logic [P_ROM_AW-1:0] IDX_ONE  = {{(P_ROM_AW-1){1'b0}}, 1'b1};

  state_e              state_d,     state_q;
  logic [P_ROM_AW-1:0] idx_d,       idx_q;
  logic                fetch_cnt_d, fetch_cnt_q;
  logic [23:0]         tmo_cnt_d,   tmo_cnt_q;
  logic [15:0]         pre_cnt_d,   pre_cnt_q;
  logic [7:0]          unit_cnt_d,  unit_cnt_q;
  logic                auto_pend_d, auto_pend_q;
  logic [2:0]          mcmd_d,      mcmd_q;
  logic [14:0]         maddr_d,     maddr_q;
  logic [7:0]          mdata_d,     mdata_q;
  logic                busy_d,      busy_q;
  logic                done_d,      done_q;
  logic                error_d,     error_q;
  logic [1:0]          err_code_d,  err_code_q;
  logic [P_ROM_AW-1:0] err_idx_d,   err_idx_q;

  logic [ENTRY_W-1:0]  rom_data_s;
  entry_t              rom_entry_s;
  logic                tmo_hit_s;
  logic                abort_s;
  logic [1:0]          abort_code_s;
  logic                adv_s;

  sccb_init_rom #(
    .P_ROM_AW    (P_ROM_AW),
    .P_ROM_TABLE (P_ROM_TABLE)
  ) u_rom (
    .clk   (sccb_clk),
    .addr  (idx_q),
    .entry (rom_data_s)
  );

  // The ROM keeps presenting the current entry while idx_q is unchanged,
  // so ISSUE/WAIT_RESP can use its fields directly.
  assign rom_entry_s = entry_t'(rom_data_s);

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fetch_cnt_d  = fetch_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    pre_cnt_d    = pre_cnt_q;
    unit_cnt_d   = unit_cnt_q;
    auto_pend_d  = 1'b0;
    mcmd_d       = mcmd_q;
    maddr_d      = maddr_q;
    mdata_d      = mdata_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    err_idx_d    = err_idx_q;
    abort_s      = 1'b0;
    abort_code_s = ERR_NONE;
    adv_s        = 1'b0;
    tmo_hit_s    = (tmo_cnt_q == (P_TIMEOUT - 24'd1));

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start || auto_pend_q) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_code_d  = ERR_NONE;
          idx_d       = '0;
          fetch_cnt_d = 1'b0;
          state_d     = S_FETCH;
        end else begin
          state_d = state_q;
        end
      end

      // First cycle presents idx_q to the ROM, second sees its output.
      S_FETCH: begin
        if (fetch_cnt_q == 1'b0) begin
          fetch_cnt_d = 1'b1;
        end else begin
          fetch_cnt_d = 1'b0;
          case (rom_entry_s.op)
            OP_WRITE, OP_CHECK: begin
              tmo_cnt_d = 24'd0;
              state_d   = S_ISSUE;
            end
            OP_DELAY: begin
              pre_cnt_d  = 16'd0;
              unit_cnt_d = rom_entry_s.data;
              state_d    = S_DELAY;
            end
            OP_END: begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
            default: begin
              state_d = S_FETCH;
            end
          endcase
        end
      end

      S_ISSUE: begin
        if (tmo_hit_s) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TIMEOUT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
          if (scmdaccept) begin
            mcmd_d  = (rom_entry_s.op == OP_CHECK) ? MCMD_READ : MCMD_WRITE;
            maddr_d = {P_DEV_ID, rom_entry_s.addr};
            mdata_d = rom_entry_s.data;
            state_d = S_WAIT_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      // Command stays on the bus until DVA is sampled.
      S_WAIT_RESP: begin
        if (tmo_hit_s) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TIMEOUT;
        end else if (sresp == SRESP_DVA) begin
          mcmd_d = MCMD_IDLE;
          if ((rom_entry_s.op == OP_CHECK) && (sdata != rom_entry_s.data)) begin
            abort_s      = 1'b1;
            abort_code_s = ERR_CHECK;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 24'd1;
            state_d   = S_WAIT_IDLE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      // Bridge raises scmdaccept again once its STOP condition is done.
      S_WAIT_IDLE: begin
        if (tmo_hit_s) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TIMEOUT;
        end else if (scmdaccept) begin
          adv_s = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      // unit_cnt counts remaining delay units, pre_cnt the cycles in a unit.
      S_DELAY: begin
        if (unit_cnt_q == 8'd0) begin
          adv_s = 1'b1;
        end else if (pre_cnt_q == (P_MS_DIV - 16'd1)) begin
          pre_cnt_d  = 16'd0;
          unit_cnt_d = unit_cnt_q - 8'd1;
        end else begin
          pre_cnt_d = pre_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Finishing the last slot without END is an overrun; the index never wraps.
    if (abort_s || (adv_s && (idx_q == IDX_LAST))) begin
      state_d    = S_ERROR;
      error_d    = 1'b1;
      err_code_d = abort_s ? abort_code_s : ERR_OVERRUN;
      err_idx_d  = idx_q;
      mcmd_d     = MCMD_IDLE;
    end else if (adv_s) begin
      idx_d       = idx_q + IDX_ONE;
      fetch_cnt_d = 1'b0;
      state_d     = S_FETCH;
    end else begin
      idx_d = idx_d;
    end

    // Only ISSUE->WAIT_RESP may carry a live command.
    if ((state_d == S_WAIT_RESP) || (state_d == S_WAIT_IDLE) || (state_d == S_ISSUE)) begin
      mcmd_d = mcmd_d;
    end else begin
      mcmd_d = MCMD_IDLE;
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERROR);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge sccb_clk or negedge sccb_reset_n) begin
    if (!sccb_reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      fetch_cnt_q <= 1'b0;
      tmo_cnt_q   <= 24'd0;
      pre_cnt_q   <= 16'd0;
      unit_cnt_q  <= 8'd0;
      auto_pend_q <= P_AUTO_START;
      mcmd_q      <= MCMD_IDLE;
      maddr_q     <= 15'd0;
      mdata_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fetch_cnt_q <= fetch_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      unit_cnt_q  <= unit_cnt_d;
      auto_pend_q <= auto_pend_d;
      mcmd_q      <= mcmd_d;
      maddr_q     <= maddr_d;
      mdata_q     <= mdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign mcmd     = mcmd_q;
  assign maddr    = maddr_q;
  assign mdata    = mdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq
//   Two sequencer instances: dut_a runs the bring-up table against a
//   randomized bridge model with a register-file; dut_b runs the
//   all-WRITE table to exercise table overrun.
module tb_sccb_init_seq;
  import sccb_init_seq_pkg::*;

  localparam logic [15:0] DIV  = 16'd10;
  localparam logic [23:0] TMO  = 24'd100;
  localparam int          B_AW = 3;

  typedef logic [25:0] cmd_t;   // {mcmd, maddr, mdata}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a, scmdaccept_a, busy_a, done_a, error_a;
  logic [2:0]  mcmd_a;
  logic [14:0] maddr_a;
  logic [7:0]  mdata_a, sdata_a;
  logic [1:0]  sresp_a, err_code_a;
  logic [5:0]  err_idx_a;

  logic        start_b, scmdaccept_b, busy_b, done_b, error_b;
  logic [2:0]  mcmd_b;
  logic [14:0] maddr_b;
  logic [7:0]  mdata_b, sdata_b;
  logic [1:0]  sresp_b, err_code_b;
  logic [B_AW-1:0] err_idx_b;

  sccb_init_seq #(.P_DEV_ID(7'h21), .P_ROM_AW(6), .P_MS_DIV(DIV), .P_TIMEOUT(TMO),
                  .P_AUTO_START(1'b1), .P_ROM_TABLE(0)) dut_a (
    .sccb_clk(clk), .sccb_reset_n(rst_n), .start(start_a), .mcmd(mcmd_a),
    .maddr(maddr_a), .mdata(mdata_a), .scmdaccept(scmdaccept_a), .sresp(sresp_a),
    .sdata(sdata_a), .busy(busy_a), .done(done_a), .error(error_a),
    .err_code(err_code_a), .err_idx(err_idx_a));

  sccb_init_seq #(.P_DEV_ID(7'h21), .P_ROM_AW(B_AW), .P_MS_DIV(DIV), .P_TIMEOUT(TMO),
                  .P_AUTO_START(1'b1), .P_ROM_TABLE(1)) dut_b (
    .sccb_clk(clk), .sccb_reset_n(rst_n), .start(start_b), .mcmd(mcmd_b),
    .maddr(maddr_b), .mdata(mdata_b), .scmdaccept(scmdaccept_b), .sresp(sresp_b),
    .sdata(sdata_b), .busy(busy_b), .done(done_b), .error(error_b),
    .err_code(err_code_b), .err_idx(err_idx_b));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference table for dut_a and what it implies.
  op_e        t_op[6];
  logic [7:0] t_addr[6];
  logic [7:0] t_data[6];
  cmd_t       exp_q[$];
  int         exp_delay;
  int         exp_chk_idx;

  // Bridge model A state.
  logic [7:0] regs[256];
  cmd_t       cmd_q_a[$];
  cmd_t       cur_a;
  int         mode_a = 0;     // 0 normal, 1 corrupt read data, 2 never DVA
  int         ba_state = 0;
  int         lat_a = 0;
  int         gap_a = 0;
  int         hold_err = 0;
  int         last_acc_edge = 0;

  // Bridge model B state.
  int bb_state = 0;
  int cnt_b = 0;
  int b_addr_err = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Derive expected bus traffic and post-CHECK timing from the table rules.
  task automatic build_model();
    bit after_chk;
    t_op[0] = OP_WRITE; t_addr[0] = 8'h12; t_data[0] = 8'h80;
    t_op[1] = OP_WRITE; t_addr[1] = 8'h11; t_data[1] = 8'h01;
    t_op[2] = OP_CHECK; t_addr[2] = 8'h0A; t_data[2] = 8'h76;
    t_op[3] = OP_DELAY; t_addr[3] = 8'h00; t_data[3] = 8'h00;
    t_op[4] = OP_DELAY; t_addr[4] = 8'h00; t_data[4] = 8'h03;
    t_op[5] = OP_END;   t_addr[5] = 8'h00; t_data[5] = 8'h00;
    exp_q.delete();
    exp_delay = 0;
    exp_chk_idx = -1;
    after_chk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (t_op[i] == OP_WRITE) exp_q.push_back({3'b001, 7'h21, t_addr[i], t_data[i]});
      if (t_op[i] == OP_CHECK) begin
        exp_q.push_back({3'b010, 7'h21, t_addr[i], t_data[i]});
        exp_chk_idx = i;
      end
      // Each later entry costs a 2-cycle fetch plus its own wait.
      if (after_chk) begin
        exp_delay += 2;
        if (t_op[i] == OP_DELAY)
          exp_delay += (t_data[i] == 8'd0) ? 1 : int'(t_data[i]) * int'(DIV);
      end
      if (t_op[i] == OP_CHECK) after_chk = 1'b1;
    end
  endtask

  task automatic reset_regs();
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[8'h0A] = 8'h76;
  endtask

  // Bridge model A: random response latency and STOP length, register file.
  initial begin
    scmdaccept_a = 1'b1; sresp_a = 2'b00; sdata_a = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ba_state = 0; scmdaccept_a = 1'b1; sresp_a = 2'b00;
      end else begin
        case (ba_state)
          0: begin
            sresp_a = 2'b00;
            if (mcmd_a != 3'b000) begin
              cur_a = {mcmd_a, maddr_a, mdata_a};
              cmd_q_a.push_back(cur_a);
              scmdaccept_a = 1'b0;
              lat_a = $urandom_range(1, 4);
              ba_state = 1;
            end
          end
          1: begin
            if (error_a) begin
              ba_state = 0; scmdaccept_a = 1'b1;
            end else begin
              if ({mcmd_a, maddr_a, mdata_a} !== cur_a) hold_err++;
              if (mode_a != 2) begin
                lat_a--;
                if (lat_a == 0) begin
                  sresp_a = 2'b01;
                  if (cur_a[25:23] == 3'b010)
                    sdata_a = regs[cur_a[15:8]] ^ ((mode_a == 1) ? 8'h05 : 8'h00);
                  else begin
                    regs[cur_a[15:8]] = cur_a[7:0];
                    sdata_a = 8'($urandom);
                  end
                  ba_state = 2;
                end
              end
            end
          end
          2: begin
            sresp_a = 2'b00;
            if (!error_a && mcmd_a !== 3'b000) hold_err++;
            gap_a = $urandom_range(0, 3);
            if (gap_a == 0) begin
              scmdaccept_a = 1'b1; last_acc_edge = cyc + 1; ba_state = 0;
            end else ba_state = 3;
          end
          default: begin
            gap_a--;
            if (gap_a <= 0) begin
              scmdaccept_a = 1'b1; last_acc_edge = cyc + 1; ba_state = 0;
            end
          end
        endcase
      end
    end
  end

  // Bridge model B: fixed latency, checks write order.
  initial begin
    scmdaccept_b = 1'b1; sresp_b = 2'b00; sdata_b = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bb_state = 0; scmdaccept_b = 1'b1; sresp_b = 2'b00; cnt_b = 0; b_addr_err = 0;
      end else begin
        case (bb_state)
          0: if (mcmd_b != 3'b000) begin
            if (mcmd_b !== 3'b001 || maddr_b !== {7'h21, 8'(cnt_b)} || mdata_b !== ~8'(cnt_b))
              b_addr_err++;
            cnt_b++;
            scmdaccept_b = 1'b0;
            bb_state = 1;
          end
          1: begin sresp_b = 2'b01; bb_state = 2; end
          default: begin sresp_b = 2'b00; scmdaccept_b = 1'b1; bb_state = 0; end
        endcase
      end
    end
  end

  task automatic pulse_start_a();
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mcmd_a !== 3'b000) begin n_errors++; $display("FAIL reset_mcmd: got %0h expected 0", mcmd_a); end
    n_checks++; if (maddr_a !== 15'd0) begin n_errors++; $display("FAIL reset_maddr: got %0h expected 0", maddr_a); end
    n_checks++; if (mdata_a !== 8'd0) begin n_errors++; $display("FAIL reset_mdata: got %0h expected 0", mdata_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0b expected 0", done_a); end
    n_checks++; if (error_a !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %0b expected 0", error_a); end
    n_checks++; if (err_code_a !== 2'b00) begin n_errors++; $display("FAIL reset_err_code: got %0h expected 0", err_code_a); end
    n_checks++; if (err_idx_a !== 6'd0) begin n_errors++; $display("FAIL reset_err_idx: got %0h expected 0", err_idx_a); end
    n_checks++; if (busy_b !== 1'b0 || error_b !== 1'b0) begin n_errors++; $display("FAIL reset_b: got busy=%0b error=%0b expected 0 0", busy_b, error_b); end
  endtask

  task automatic test_auto_sequence();
    int done_cyc;
    int d;
    mode_a = 0; hold_err = 0; cmd_q_a.delete(); reset_regs();
    rst_n = 1'b1;
    for (int i = 0; i < 200 && mcmd_a == 3'b000; i++) begin @(posedge clk); #1; end
    n_checks++; if (busy_a !== 1'b1) begin n_errors++; $display("FAIL auto_busy_running: got %0b expected 1", busy_a); end
    for (int i = 0; i < 2000 && !done_a; i++) begin @(posedge clk); #1; end
    done_cyc = cyc;
    n_checks++; if (done_a !== 1'b1) begin n_errors++; $display("FAIL auto_done: got %0b expected 1", done_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL auto_busy_end: got %0b expected 0", busy_a); end
    n_checks++; if (error_a !== 1'b0) begin n_errors++; $display("FAIL auto_error: got %0b expected 0", error_a); end
    n_checks++; if (cmd_q_a.size() != exp_q.size()) begin n_errors++; $display("FAIL auto_cmd_count: got %0d expected %0d", cmd_q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cmd_q_a.size(); i++) begin
      n_checks++; if (cmd_q_a[i] !== exp_q[i]) begin n_errors++; $display("FAIL auto_cmd%0d: got %h expected %h", i, cmd_q_a[i], exp_q[i]); end
    end
    n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL auto_cmd_hold: got %0d unstable cycles expected 0", hold_err); end
    d = done_cyc - last_acc_edge;
    n_checks++; if (d < exp_delay - 4 || d > exp_delay + 4) begin n_errors++; $display("FAIL auto_delay_timing: got %0d cycles expected %0d +/-4", d, exp_delay); end
    n_checks++; if (mcmd_a !== 3'b000) begin n_errors++; $display("FAIL auto_mcmd_idle: got %0h expected 0", mcmd_a); end
  endtask

  task automatic test_back_to_back();
    mode_a = 0; hold_err = 0; cmd_q_a.delete();
    repeat ($urandom_range(0, 5)) @(posedge clk);
    pulse_start_a();
    n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL b2b_done_cleared: got %0b expected 0", done_a); end
    for (int i = 0; i < 200 && mcmd_a == 3'b000; i++) begin @(posedge clk); #1; end
    repeat ($urandom_range(1, 10)) @(posedge clk);
    pulse_start_a();   // busy: must not restart the table
    for (int i = 0; i < 2000 && !done_a; i++) begin @(posedge clk); #1; end
    n_checks++; if (done_a !== 1'b1) begin n_errors++; $display("FAIL b2b_done: got %0b expected 1", done_a); end
    n_checks++; if (cmd_q_a.size() != exp_q.size()) begin n_errors++; $display("FAIL b2b_cmd_count: got %0d expected %0d", cmd_q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cmd_q_a.size(); i++) begin
      n_checks++; if (cmd_q_a[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_cmd%0d: got %h expected %h", i, cmd_q_a[i], exp_q[i]); end
    end
    n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL b2b_cmd_hold: got %0d expected 0", hold_err); end
  endtask

  task automatic test_check_mismatch();
    mode_a = 1; cmd_q_a.delete();
    pulse_start_a();
    for (int i = 0; i < 2000 && !error_a; i++) begin @(posedge clk); #1; end
    n_checks++; if (error_a !== 1'b1) begin n_errors++; $display("FAIL chk_error: got %0b expected 1", error_a); end
    n_checks++; if (err_code_a !== ERR_CHECK) begin n_errors++; $display("FAIL chk_err_code: got %0h expected %0h", err_code_a, ERR_CHECK); end
    n_checks++; if (err_idx_a !== 6'(exp_chk_idx)) begin n_errors++; $display("FAIL chk_err_idx: got %0d expected %0d", err_idx_a, exp_chk_idx); end
    n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_errors++; $display("FAIL chk_flags: got done=%0b busy=%0b expected 0 0", done_a, busy_a); end
    n_checks++; if (mcmd_a !== 3'b000) begin n_errors++; $display("FAIL chk_mcmd: got %0h expected 0", mcmd_a); end
    // Restart from ERROR with a good ID.
    mode_a = 0;
    pulse_start_a();
    n_checks++; if (error_a !== 1'b0 || err_code_a !== 2'b00) begin n_errors++; $display("FAIL chk_restart_clear: got error=%0b code=%0h expected 0 0", error_a, err_code_a); end
    for (int i = 0; i < 2000 && !done_a; i++) begin @(posedge clk); #1; end
    n_checks++; if (done_a !== 1'b1) begin n_errors++; $display("FAIL chk_restart_done: got %0b expected 1", done_a); end
  endtask

  task automatic test_timeout();
    int c0;
    int d;
    mode_a = 2;
    pulse_start_a();
    for (int i = 0; i < 200 && mcmd_a == 3'b000; i++) begin @(posedge clk); #1; end
    c0 = cyc;
    for (int i = 0; i < 400 && !error_a; i++) begin @(posedge clk); #1; end
    d = cyc - c0;
    n_checks++; if (error_a !== 1'b1) begin n_errors++; $display("FAIL tmo_error: got %0b expected 1", error_a); end
    n_checks++; if (d < int'(TMO) - 3 || d > int'(TMO) + 1) begin n_errors++; $display("FAIL tmo_timing: got %0d expected %0d +/-2", d, int'(TMO) - 1); end
    n_checks++; if (err_code_a !== ERR_TIMEOUT) begin n_errors++; $display("FAIL tmo_err_code: got %0h expected %0h", err_code_a, ERR_TIMEOUT); end
    n_checks++; if (err_idx_a !== 6'd0) begin n_errors++; $display("FAIL tmo_err_idx: got %0d expected 0", err_idx_a); end
    n_checks++; if (mcmd_a !== 3'b000) begin n_errors++; $display("FAIL tmo_mcmd: got %0h expected 0", mcmd_a); end
  endtask

  task automatic test_reset_mid();
    mode_a = 2;
    pulse_start_a();
    for (int i = 0; i < 200 && mcmd_a == 3'b000; i++) begin @(posedge clk); #1; end
    repeat ($urandom_range(1, 20)) @(posedge clk);
    #3;
    n_checks++; if (mcmd_a === 3'b000) begin n_errors++; $display("FAIL rstmid_cmd_live: got %0h expected nonzero", mcmd_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (mcmd_a !== 3'b000) begin n_errors++; $display("FAIL rstmid_async_mcmd: got %0h expected 0", mcmd_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL rstmid_async_busy: got %0b expected 0", busy_a); end
    repeat (2) @(posedge clk);
    #1;
    mode_a = 0; hold_err = 0; cmd_q_a.delete(); reset_regs();
    rst_n = 1'b1;
    for (int i = 0; i < 2000 && !done_a; i++) begin @(posedge clk); #1; end
    n_checks++; if (done_a !== 1'b1) begin n_errors++; $display("FAIL rstmid_autorestart_done: got %0b expected 1", done_a); end
    n_checks++; if (cmd_q_a.size() == 0 || cmd_q_a[0] !== exp_q[0]) begin n_errors++; $display("FAIL rstmid_first_cmd: got %h expected %h", (cmd_q_a.size() == 0) ? 26'h0 : cmd_q_a[0], exp_q[0]); end
    n_checks++; if (cmd_q_a.size() != exp_q.size()) begin n_errors++; $display("FAIL rstmid_cmd_count: got %0d expected %0d", cmd_q_a.size(), exp_q.size()); end
  endtask

  task automatic test_overrun();
    int last_b;
    last_b = (1 << B_AW) - 1;
    for (int i = 0; i < 2000 && !error_b; i++) begin @(posedge clk); #1; end
    n_checks++; if (error_b !== 1'b1) begin n_errors++; $display("FAIL ovr_error: got %0b expected 1", error_b); end
    n_checks++; if (err_code_b !== ERR_OVERRUN) begin n_errors++; $display("FAIL ovr_err_code: got %0h expected %0h", err_code_b, ERR_OVERRUN); end
    n_checks++; if (err_idx_b !== B_AW'(last_b)) begin n_errors++; $display("FAIL ovr_err_idx: got %0d expected %0d", err_idx_b, last_b); end
    n_checks++; if (cnt_b != last_b + 1) begin n_errors++; $display("FAIL ovr_write_count: got %0d expected %0d", cnt_b, last_b + 1); end
    n_checks++; if (b_addr_err != 0) begin n_errors++; $display("FAIL ovr_write_order: got %0d bad writes expected 0", b_addr_err); end
    n_checks++; if (done_b !== 1'b0 || busy_b !== 1'b0 || mcmd_b !== 3'b000) begin n_errors++; $display("FAIL ovr_flags: got done=%0b busy=%0b mcmd=%0h expected 0 0 0", done_b, busy_b, mcmd_b); end
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    build_model();
    reset_regs();
    test_reset();
    test_auto_sequence();
    test_back_to_back();
    test_check_mismatch();
    test_timeout();
    test_reset_mid();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
